// File: rtl/fifo_reader_pkg.sv
// Shared types and sizes for the FIFO read-side master and its skid buffer.
// The optional delivered-word counter is enabled by FIFO_READER_CNT_EN.
package fifo_reader_pkg;

    localparam int SKID_DEPTH = 2;

    typedef logic [1:0]  occ_t;
    typedef logic [15:0] wcnt_t;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream seen by fifo_reader.
interface fifo_reader_if #(
    parameter int DW = 8
);

    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer: 1-bit wrapping pointers, occupancy count, FIFO ordering.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] data,
    output occ_t          occ
);

    logic          wptr;
    logic          rptr;
    logic [DW-1:0] mem [SKID_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= '0;
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else begin
            if (wr) begin
                wptr <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            occ <= occ + occ_t'(wr) - occ_t'(pop);
        end
    end

    // Storage is deliberately left unreset; occ gates whether it is visible.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= wr_data;
        end
    end

    assign valid = (occ != 2'd0);
    assign data  = mem[rptr];

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for the 16-entry FIFO: issues rd, captures dout, feeds a skid buffer.
// Define FIFO_READER_CNT_EN to add the words_out delivered-word counter.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    fifo_reader_if.master    bus
`ifdef FIFO_READER_CNT_EN
    ,
    output wcnt_t            words_out
`endif
);

    logic       inflight_q;
    logic       pop;
    logic       valid;
    occ_t       occ;
    logic [2:0] pending;

    assign pop = valid && bus.m_ready;

    // Slots already committed after this cycle's pop; a new read needs one free.
    assign pending     = 3'(occ) + 3'(inflight_q) - 3'(pop);
    assign bus.fifo_rd = rst_n && en && !bus.fifo_empty && (pending <= 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= bus.fifo_rd;
        end
    end

    fifo_reader_skid #(
        .DW (DW)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (inflight_q),
        .wr_data (bus.fifo_dout),
        .pop     (pop),
        .valid   (valid),
        .data    (bus.m_data),
        .occ     (occ)
    );

    assign bus.m_valid = valid;

`ifdef FIFO_READER_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_out <= '0;
        end else if (pop) begin
            words_out <= words_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: behavioural FIFO, random and directed stimulus.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    fifo_reader_if #(.DW(DW)) bus ();

`ifdef FIFO_READER_CNT_EN
    wcnt_t words_out;
`endif

    fifo_reader #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
`ifdef FIFO_READER_CNT_EN
        ,
        .words_out (words_out)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 16-entry FIFO with rd priority over wr and registered dout.
    logic [DW-1:0] fmem [16];
    int            fcnt = 0;
    int            frp = 0;
    int            fwp = 0;
    logic [DW-1:0] wq[$];
    logic [DW-1:0] exp_q[$];
    bit            src_mode = 1'b0;
    int            src_left = 0;
    logic [DW-1:0] src_val = '0;

    int issued = 0;
    int popped = 0;
    int discarded = 0;
    int exp_words = 0;
    int vectors = 0;
    int miscompares = 0;

    assign bus.fifo_empty = src_mode ? (src_left == 0) : (fcnt == 0);

    always @(posedge clk) begin
        if (bus.fifo_rd) begin
            issued <= issued + 1;
        end
        if (src_mode) begin
            if (bus.fifo_rd && src_left != 0) begin
                bus.fifo_dout <= src_val;
                exp_q.push_back(src_val);
                src_val  <= src_val + 8'd1;
                src_left <= src_left - 1;
            end
        end else if (bus.fifo_rd && fcnt != 0) begin
            bus.fifo_dout <= fmem[frp];
            frp  <= (frp + 1) % 16;
            fcnt <= fcnt - 1;
        end else if (wq.size() != 0 && fcnt < 16) begin
            fmem[fwp] <= wq[0];
            exp_q.push_back(wq.pop_front());
            fwp  <= (fwp + 1) % 16;
            fcnt <= fcnt + 1;
        end
    end

    task automatic check_output(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and watches the invariants.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            check_output("rd_when_empty", longint'(bus.fifo_rd && bus.fifo_empty), 0);
            check_output("occ_bound", longint'((issued - popped - discarded) <= 2), 1);
`ifdef FIFO_READER_CNT_EN
            check_output("words_out", longint'(words_out), longint'(exp_words % 65536));
`endif
            if (prev_stall) begin
                check_output("hold_valid", longint'(bus.m_valid), 1);
                check_output("hold_data", longint'(bus.m_data), longint'(prev_data));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("sb_unexpected_word", 1, 0);
                end else begin
                    check_output("sb_data", longint'(bus.m_data), longint'(exp_q.pop_front()));
                end
                popped++;
                exp_words++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic apply_stimulus(input bit e, input bit r);
        @(posedge clk);
        #1;
        en          = e;
        bus.m_ready = r;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        en          = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (wq.size() == 0) && bus.fifo_empty && !bus.m_valid && (exp_q.size() == 0)
                   && (issued - popped - discarded == 0);
        end
        if (!done) begin
            check_output("drain_timeout", 1, 0);
        end
    endtask

    task automatic preload(input int n, input logic [DW-1:0] first);
        apply_stimulus(1'b0, 1'b1);
        for (int i = 0; i < n; i++) begin
            wq.push_back(first + DW'(i));
        end
        for (int i = 0; i < 60 && fcnt != n; i++) begin
            @(posedge clk);
        end
        #1;
        check_output("preload_fill", fcnt, n);
    endtask

    task automatic do_reset(output int lost);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("rst_m_valid", longint'(bus.m_valid), 0);
        check_output("rst_fifo_rd", longint'(bus.fifo_rd), 0);
        lost = issued - popped - discarded;
        for (int i = 0; i < lost && exp_q.size() != 0; i++) begin
            void'(exp_q.pop_front());
        end
        discarded += lost;
        exp_words = 0;
        repeat (2) @(posedge clk);
        #1;
        en    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("post_rst_no_stale", longint'(bus.m_valid), 0);
        end
    endtask

    initial begin
        bit rd_log [24];
        bit v_log [24];
        logic [DW-1:0] d_log [24];
        int lost;
        int ones;
        int gaps;
        int first;
        int last;
        int p0;

        rst_n       = 1'b1;
        en          = 1'b0;
        bus.m_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_output("reset_m_valid", longint'(bus.m_valid), 0);
        check_output("reset_fifo_rd", longint'(bus.fifo_rd), 0);
`ifdef FIFO_READER_CNT_EN
        check_output("reset_words_out", longint'(words_out), 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] streaming");
        preload(16, 8'h01);
        apply_stimulus(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rd_log[i] = bus.fifo_rd;
            v_log[i]  = bus.m_valid;
            d_log[i]  = bus.m_data;
        end
        for (int i = 0; i < 20; i++) begin
            check_output($sformatf("stream_rd[%0d]", i), longint'(rd_log[i]), longint'(i < 16));
            check_output($sformatf("stream_valid[%0d]", i), longint'(v_log[i]),
                         longint'(i >= 2 && i <= 17));
            if (i >= 2 && i <= 17) begin
                check_output($sformatf("stream_data[%0d]", i), longint'(d_log[i]), longint'(i - 1));
            end
        end
        drain();

        $display("[TB] backpressure");
        preload(16, 8'h40);
        repeat (5) apply_stimulus(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b0);
            @(negedge clk);
            check_output("bp_rd_low", longint'(bus.fifo_rd), 0);
            check_output("bp_valid", longint'(bus.m_valid), 1);
        end
        check_output("bp_buffered", issued - popped - discarded, 2);
        apply_stimulus(1'b1, 1'b1);
        @(negedge clk);
        check_output("bp_recovery_rd", longint'(bus.fifo_rd), 1);
        drain();

        $display("[TB] enable gap");
        preload(16, 8'h80);
        p0 = popped;
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(i != 4, 1'b1);
            @(negedge clk);
            rd_log[i] = bus.fifo_rd;
        end
        ones = 0; first = -1; last = -1; gaps = 0;
        for (int i = 0; i < 24; i++) begin
            if (rd_log[i]) begin
                ones++;
                if (first < 0) first = i;
                last = i;
            end
        end
        for (int i = 0; i < 24; i++) begin
            if (i > first && i < last && !rd_log[i]) gaps++;
        end
        check_output("en_rd_total", ones, 16);
        check_output("en_rd_gaps", gaps, 1);
        check_output("en_gap_cycle", longint'(rd_log[4]), 0);
        drain();
        check_output("en_delivered", popped - p0, 16);

        $display("[TB] empty gating");
        wq.push_back(8'hA5);
        for (int i = 0; i < 10 && bus.fifo_empty; i++) begin
            @(negedge clk);
        end
        check_output("gate_empty_fell", longint'(bus.fifo_empty), 0);
        check_output("gate_rd", longint'(bus.fifo_rd), 1);
        @(negedge clk);
        check_output("gate_rd_single", longint'(bus.fifo_rd), 0);
        @(negedge clk);
        check_output("gate_valid", longint'(bus.m_valid), 1);
        check_output("gate_data", longint'(bus.m_data), 8'hA5);
        drain();

        $display("[TB] reset mid-stream");
        preload(16, 8'hC0);
        repeat (4) apply_stimulus(1'b1, 1'b1);
        repeat (3) apply_stimulus(1'b1, 1'b0);
        do_reset(lost);
        check_output("rst_occ2", lost, 2);
        drain();

        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            if (wq.size() < 3 && $urandom_range(0, 1) != 0) begin
                wq.push_back(DW'($urandom));
            end
            apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            if (c == 700) begin
                do_reset(lost);
            end
        end
        drain();

`ifdef FIFO_READER_CNT_EN
        $display("[TB] counter wrap");
        do_reset(lost);
        src_mode = 1'b1;
        src_left = 65537;
        en          = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 66000 && src_left != 0; i++) begin
            @(posedge clk);
        end
        check_output("wrap_source_done", src_left, 0);
        drain();
        #1;
        check_output("wrap_words_out", longint'(words_out), 1);
        src_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
